// File: rtl/multiplier.sv
// ============================================================================
// Module   : multiplier
// Purpose  : Sequential unsigned shift-add multiplier, one multiplier bit per
//            enabled clock, with a start/done handshake and clock enable.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiplier #(
  parameter int C_NUM_BITS = 4
) (
  input  logic                      CK,
  input  logic                      RN,
  input  logic                      E,
  input  logic                      START,
  input  logic [C_NUM_BITS-1:0]     A,
  input  logic [C_NUM_BITS-1:0]     B,
  output logic [2*C_NUM_BITS-1:0]   P,
  output logic                      BUSY,
  output logic                      DONE
);

  localparam int N  = C_NUM_BITS;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] C_CNT_INIT = CW'(N);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_mcand;
  logic [N:0]      r_acc;
  logic [N-1:0]    r_mplr;
  logic [CW-1:0]   r_cnt;
  logic [N:0]      w_sum;

  // ACC's top bit is always zero after each shift, so the full-width add is exact.
  assign w_sum = r_acc + (r_mplr[0] ? {1'b0, r_mcand} : '0);

  always_ff @(posedge CK) begin
    if (!RN) begin
      r_state <= S_IDLE;
      r_mcand <= '0;
      r_acc   <= '0;
      r_mplr  <= '0;
      r_cnt   <= '0;
      P       <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else if (E) begin
      case (r_state)
        S_IDLE, S_DONE: begin
          DONE <= 1'b0;
          if (START) begin
            r_mcand <= A;
            r_mplr  <= B;
            r_acc   <= '0;
            r_cnt   <= C_CNT_INIT;
            BUSY    <= 1'b1;
            r_state <= S_RUN;
          end else begin
            BUSY    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_acc  <= {1'b0, w_sum[N:1]};
          r_mplr <= {w_sum[0], r_mplr[N-1:1]};
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == C_CNT_LAST) begin
            // Publish the product as it looks after this final shift.
            P       <= {w_sum, r_mplr[N-1:1]};
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          BUSY    <= 1'b0;
          DONE    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multiplier.sv
// ============================================================================
// Module   : tb_multiplier
// Purpose  : Scoreboard bench for multiplier: stimulus pushes expected product
//            and due enabled-edge index; a monitor pops on each DONE.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multiplier;

  localparam int N  = 4;
  localparam int PW = 2 * N;

  logic          CK = 1'b0;
  logic          RN = 1'b0;
  logic          E = 1'b1;
  logic          START = 1'b0;
  logic [N-1:0]  A = '0;
  logic [N-1:0]  B = '0;
  logic [PW-1:0] P;
  logic          BUSY;
  logic          DONE;

  typedef struct {
    logic [PW-1:0] prod;
    int            due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   en_cnt = 0;

  multiplier #(.C_NUM_BITS(N)) dut (
    .CK(CK), .RN(RN), .E(E), .START(START),
    .A(A), .B(B), .P(P), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CK = ~CK;

  // Monitor: counts enabled edges and checks every freshly produced result.
  initial begin
    logic en, rn;
    exp_t e;
    forever begin
      @(posedge CK);
      en = E;
      rn = RN;
      if (rn && en) en_cnt++;
      #1;
      checks++;
      if (BUSY && DONE) begin
        errors++;
        $display("FAIL busy_done_overlap: BUSY=%0b DONE=%0b required not both high", BUSY, DONE);
      end
      if (rn && en && DONE) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: P=%0d at edge %0d, no result expected", P, en_cnt);
        end else begin
          e = q.pop_front();
          if (P !== e.prod || en_cnt != e.due) begin
            errors++;
            $display("FAIL result: P=%0d at edge %0d, required P=%0d at edge %0d",
                     P, en_cnt, e.prod, e.due);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Called right after a negedge with E=1 and the block idle or done.
  task automatic start_op(input int a, input int b);
    exp_t e;
    A = N'(a);
    B = N'(b);
    START = 1'b1;
    @(posedge CK);
    #2;
    e.prod = PW'(a * b);
    e.due  = en_cnt + N;
    q.push_back(e);
    @(negedge CK);
    START = 1'b0;
  endtask

  task automatic wait_done(output int busy_cycles);
    int guard = 0;
    busy_cycles = 0;
    while (!DONE && guard < 200) begin
      if (BUSY) busy_cycles++;
      @(negedge CK);
      guard++;
    end
    if (!DONE) check("done_timeout", 0, 1);
  endtask

  initial begin
    int bc;
    repeat (2) @(negedge CK);
    check("reset_P", int'(P), 0);
    check("reset_BUSY", int'(BUSY), 0);
    check("reset_DONE", int'(DONE), 0);
    RN = 1'b1;
    @(negedge CK);

    // Basic 13 x 11
    start_op(13, 11);
    wait_done(bc);
    check("basic_busy_cycles", bc, N);
    check("basic_P", int'(P), 143);
    @(negedge CK);
    check("basic_done_one_cycle", int'(DONE), 0);
    check("basic_P_hold", int'(P), 143);

    // Corner operands
    begin
      int ca[5] = '{15, 0, 9, 1, 8};
      int cb[5] = '{15, 9, 0, 15, 2};
      for (int i = 0; i < 5; i++) begin
        start_op(ca[i], cb[i]);
        wait_done(bc);
        check("corner_busy_cycles", bc, N);
        @(negedge CK);
      end
    end

    // Stall mid-run, then E=0 while DONE is high
    start_op(7, 6);
    @(negedge CK);
    E = 1'b0;
    repeat (3) @(negedge CK);
    E = 1'b1;
    wait_done(bc);
    E = 1'b0;
    repeat (2) @(negedge CK);
    check("stall_done_held", int'(DONE), 1);
    check("stall_P_held", int'(P), 42);
    E = 1'b1;
    @(negedge CK);
    check("stall_done_release", int'(DONE), 0);

    // START during RUN is ignored
    start_op(5, 3);
    A = 4'd15;
    B = 4'd15;
    START = 1'b1;
    @(negedge CK);
    START = 1'b0;
    wait_done(bc);
    check("ignored_start_P", int'(P), 15);
    // Back-to-back from the DONE cycle
    start_op(12, 12);
    wait_done(bc);
    check("b2b_P", int'(P), 144);
    @(negedge CK);

    // Reset during RUN cycle 2
    start_op(13, 11);
    @(negedge CK);
    RN = 1'b0;
    q.delete();
    @(negedge CK);
    RN = 1'b1;
    check("midreset_P", int'(P), 0);
    check("midreset_BUSY", int'(BUSY), 0);
    check("midreset_DONE", int'(DONE), 0);
    repeat (8) @(negedge CK);
    start_op(3, 4);
    wait_done(bc);
    check("after_reset_P", int'(P), 12);
    @(negedge CK);

    // Randomized operands with random stalls, chained back-to-back
    for (int i = 0; i < 30; i++) begin
      E = 1'b1;
      start_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      begin
        int guard = 0;
        while (!DONE && guard < 200) begin
          E = ($urandom_range(0, 3) != 0);
          @(negedge CK);
          guard++;
        end
        if (!DONE) check("rand_timeout", 0, 1);
      end
      E = 1'b1;
      if ($urandom_range(0, 1) == 0) @(negedge CK);
    end
    E = 1'b1;
    repeat (10) @(negedge CK);
    check("scoreboard_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multiplier.md
# multiplier

Sequential unsigned shift-add multiplier, the inverse companion of the team's restoring divider: it multiplies a C_NUM_BITS multiplicand by a C_NUM_BITS multiplier and returns a 2·C_NUM_BITS product. It processes one multiplier bit per enabled clock, so a 4-bit multiply takes 4 iteration cycles. It uses the same clock-enable gating (E) and start/done handshake as the divider, so the two can share a datapath controller.

## Interface
- C_NUM_BITS, default 4, operand width (≥2); product width is 2·C_NUM_BITS.

- CK  in  1  rising-edge clock.
- RN  in  1  reset, synchronous, active-low.
- E  in  1  clock enable. When low, all state holds.
- START  in  1  operation request. Sampled only when E=1 and the block is IDLE or DONE.
- A  in  C_NUM_BITS  multiplicand, unsigned. Captured on START acceptance.
- B  in  C_NUM_BITS  multiplier, unsigned. Captured on START acceptance.
- P  out  2·C_NUM_BITS  product, registered. Holds its last completed value.
- BUSY  out  1  high in the RUN state.
- DONE  out  1  high for exactly one enabled cycle when P is updated.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Internal registers:
  - MCAND (N bits), holds A.
  - ACC (N+1 bits: carry plus high half).
  - MPLR (N bits: low half / remaining multiplier bits).
  - CNT (clog2(N+1) bits).
- IDLE or DONE, E=1, START=1 (accept):
  - MCAND←A, MPLR←B, ACC←0, CNT←N.
  - Next state is RUN.
- IDLE or DONE, E=1, START=0: next state is IDLE.
- RUN, E=1, each cycle:
  - sum = ACC[N-1:0] + (MPLR[0] ? MCAND : 0), computed N+1 bits wide.
  - {ACC, MPLR} ← {sum, MPLR} >> 1, i.e. ACC←{0, sum[N:1]} and MPLR←{sum[0], MPLR[N-1:1]}.
  - CNT←CNT−1.
- RUN with CNT=1 at the edge:
  - After the final iteration, P←{ACC,MPLR}; the value is the shifted result, with ACC bit N discarded and always 0.
  - Next state is DONE.
- START during RUN is ignored, and A/B changes have no effect.
- Arithmetic is unsigned. The product never overflows 2N bits; the maximum is (2^N−1)², which is 225 for N=4.
- E=0: state, CNT, ACC, MPLR, MCAND, P, BUSY and DONE all hold, including DONE staying high.
- RN=0 at a rising edge overrides E and START:
  - State→IDLE.
  - P, ACC, MPLR, MCAND and CNT →0.
  - BUSY=0, DONE=0.
  - Reset mid-RUN aborts the operation, and no DONE pulse follows.

## Timing
- Outputs are registered; no combinational path from inputs to outputs.
- START accepted at enabled edge t0:
  - BUSY=1 for the next N enabled cycles.
  - DONE=1 and the new P are visible after enabled edge t0+N.
  - DONE stays high until the next enabled edge.
- Latency is N+1 enabled edges from START to DONE deassert.
- Back-to-back operation: START=1 in the DONE cycle is accepted, so throughput is one result per N+1 enabled cycles.
- Stalls (E=0) stretch the latency by the number of disabled cycles and corrupt nothing.
- BUSY and DONE are never both high.

## Test plan
- Basic multiply: reset, A=13, B=11, START for one cycle, E=1 throughout.
  - BUSY is high for exactly 4 cycles.
  - DONE pulses for 1 cycle with P=143 (0x8F).
  - P holds 0x8F afterwards.
- Corner operands:
  - 15×15 → P=225 (0xE1).
  - 0×9 → 0.
  - 9×0 → 0.
  - 1×15 → 15.
  - 8×2 → 16.
  - Each takes the same 4-cycle latency.
- Stall: start 7×6 and drop E for 3 cycles in the middle of RUN.
  - DONE arrives 3 cycles later than nominal, with P=42.
  - With E=0 while DONE=1, DONE stays high until an enabled edge.
- Ignored START: start 5×3, then pulse START with A=15, B=15 during RUN.
  - Result is P=15.
  - Only one DONE pulse occurs.
- Back-to-back: assert START in the DONE cycle of 5×3, with new operands 12×12.
  - The second DONE gives P=144, exactly 5 cycles after the first DONE.
- Reset mid-operation: start 13×11 and drive RN=0 for one edge during RUN cycle 2.
  - P=0, BUSY=0, DONE=0, and no DONE pulse follows.
  - A fresh 3×4 then returns P=12.
